// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// the read-port slice extractor and the write-priority encoding.
package regfile_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  // Widest packed port bus that sel_rd() can slice
  localparam int SEL_BUS_W = 256;

  // Which write port supplies a register's data when both target it
  typedef enum logic {
    WP_A = 1'b0,
    WP_B = 1'b1
  } wr_prio_e;

  // Extract field idx of width w from a packed multi-port bus
  function automatic logic [SEL_BUS_W-1:0] sel_rd(
    input logic [SEL_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [SEL_BUS_W-1:0] mask;
    mask = {SEL_BUS_W{1'b1}} >> (SEL_BUS_W - w);
    return (bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an outstanding
// long-latency write. A reserve sets the bit (and beats a same-cycle
// port B clear); a port B write clears it; otherwise it holds.
// With REGFILE_BYPASS_EN defined the next-state vector is also exported
// so forwarded reads can report the post-edge busy value.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 wb_en,
  input  logic [ADDR_W-1:0]    wb_addr,
  output logic [2**ADDR_W-1:0] busy_vec
`ifdef REGFILE_BYPASS_EN
  ,
  output logic [2**ADDR_W-1:0] busy_next
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_reg;
`ifndef REGFILE_BYPASS_EN
  logic [DEPTH-1:0] busy_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      // register 0 can never be reserved when it is hardwired to zero
      assign set_hit = rsv_en && (rsv_addr == ADDR_W'(gi)) && !((ZERO_REG != 0) && (gi == 0));
      assign clr_hit = wb_en && (wb_addr == ADDR_W'(gi));
      assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
    end
  endgenerate

  // scoreboard state; reset clears every pending reservation at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// NUM_RD combinational read ports, write port A (ALU) and port B
// (load / long-latency, also retires the busy bit), reserve port.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding
// on the read ports (port A beats port B), busy reported as next-state.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic                 wa_ok;
  logic                 wb_ok;
  logic [SEL_BUS_W-1:0] rd_addr_bus;
`ifdef REGFILE_BYPASS_EN
  logic [DEPTH-1:0]     busy_next;
`endif

  // writes aimed at a hardwired-zero register are dropped here, so the
  // array, the forwarding path and the read muxes never see them
  assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
  assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

  assign rd_addr_bus = SEL_BUS_W'(rd_addr);

  // register array; port A wins a same-address collision, so port B is
  // suppressed rather than relying on assignment order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wb_ok && !(wa_ok && (wa_addr == wb_addr))) begin
        mem[wb_addr] <= wb_data;
      end
      if (wa_ok) begin
        mem[wa_addr] <= wa_data;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy_vec (busy_vec)
`ifdef REGFILE_BYPASS_EN
    ,
    .busy_next(busy_next)
`endif
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] arr_data;
      logic [DATA_W-1:0] port_data;
      logic              port_busy;

      assign addr     = ADDR_W'(sel_rd(rd_addr_bus, gi, ADDR_W));
      assign arr_data = ((ZERO_REG != 0) && (addr == '0)) ? '0 : mem[addr];

`ifdef REGFILE_BYPASS_EN
      // forward an in-flight write (port A first); reset forces zeros
      always_comb begin
        port_data = arr_data;
        port_busy = busy_next[addr];
        if (wa_ok && (wa_addr == addr)) begin
          port_data = wa_data;
        end else if (wb_ok && (wb_addr == addr)) begin
          port_data = wb_data;
        end
        if (reset) begin
          port_data = '0;
          port_busy = 1'b0;
        end
      end
`else
      // committed contents only; new data appears one cycle after the write
      always_comb begin
        port_data = arr_data;
        port_busy = busy_vec[addr];
      end
`endif

      assign rd_data[gi*DATA_W +: DATA_W] = port_data;
      assign rd_busy[gi]                  = port_busy;
    end
  endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with integrated busy scoreboard; next generation of the processor's user-register block.
- Serves the decode/issue stage with NUM_RD combinational read ports.
- Two write ports: port A for ALU writeback, port B for load/long-latency writeback.
- Tracks which registers have an outstanding long-latency write pending, so issue logic can stall on hazards.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i is at bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy bit of each addressed register.
- wa_en  in  1  port A write enable.
- wa_addr  in  ADDR_W  port A write address.
- wa_data  in  DATA_W  port A write data.
- wb_en  in  1  port B write enable; also clears the busy bit.
- wb_addr  in  ADDR_W  port B write address.
- wb_data  in  DATA_W  port B write data.
- rsv_en  in  1  reserve request; sets the busy bit.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  2**ADDR_W  full scoreboard, bit n = register n busy.

Behaviour:
- Reset (async, active-high): all registers are 0, all busy bits are 0. Consequently rd_data = 0, rd_busy = 0 and busy_vec = 0 while reset is asserted.
- Reset asserted mid-operation: clears immediately and overrides any in-flight write or reserve in that cycle.
- Writes commit on the rising clk edge. Read data changes on the following cycle (write latency 1).
- Reads are combinational from the array: rd_data[i] = mem[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
- ZERO_REG=1:
  - Writes to address 0 are ignored on both ports.
  - Reads of address 0 return 0.
  - Reserve of address 0 is ignored, so busy[0] is always 0.
- Both write ports enabled to the same address in the same cycle: port A data wins. Port B still clears that register's busy bit.
- Different addresses on the two ports: both writes commit in the same cycle.
- Scoreboard, per register, next-state rules:
  - rsv_en at the address → busy set, regardless of a same-cycle port B write. Back-to-back reservation: the new pending write keeps the register busy.
  - Otherwise, wb_en at the address → busy cleared.
  - Otherwise → busy holds.
- Port A writes never change busy bits. A port A write to a busy register updates the data; busy stays 1.
- Reserving an already-busy register: busy stays 1; no error is flagged.
- Address arithmetic is unsigned. There is no wrap-around; every ADDR_W value is a valid register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - A read port whose address matches an enabled, non-suppressed write this cycle returns that write data combinationally; port A has priority over port B.
  - rd_busy for that port returns the busy next-state instead of the current busy bit.
- Undefined: reads return only committed array contents (1-cycle write-to-read latency).

Decomposition:
- Shared package regfile_pkg holds:
  - the default localparams DATA_W/ADDR_W;
  - function sel_rd(), which extracts read-port slices;
  - the write-priority enum {WP_A, WP_B}, used by the model and the bench.
- One natural sub-module: regfile_scoreboard. It holds the busy-bit vector and its set/clear/priority logic, and drives busy_vec.
- Array, write ports and read muxing stay in the top level.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then assert reset mid-cycle → rd_data at r5 = 0 and busy_vec = 0 immediately, before the next clk edge.
- Zero register (ZERO_REG=1): wa_en to r0 with 0x1234, and rsv_en to r0 → r0 reads 0 and busy_vec[0] = 0. Repeat with ZERO_REG=0 → r0 reads 0x1234.
- Dual-write collision: wa and wb both to r7 (A = 0xAAAA0000, B = 0x5555FFFF) with r7 previously busy → r7 = 0xAAAA0000 and busy[7] = 0 next cycle.
- Scoreboard ordering:
  - rsv r3 → busy[3] = 1.
  - Next cycle, wb r3 together with rsv r3 → busy[3] stays 1.
  - Next cycle, wb r3 alone → busy[3] = 0.
  - Port A write to a busy r9 → data updates, busy[9] stays 1.
- Bypass: wa r12 = 0x0F0F0F0F with rd_addr[1] = 12 in the same cycle.
  - REGFILE_BYPASS_EN defined → rd_data[1] = 0x0F0F0F0F that cycle.
  - Undefined → old value that cycle, new value the next cycle.
- Parameter sweep at DATA_W=16, ADDR_W=3, NUM_RD=3: write distinct patterns to all 8 registers → all three ports read back correct slices, and busy_vec is 8 bits wide.
